// File: rtl/immediate_select_pipe_pkg.sv
// Shared definitions for the immediate generator: format codes, select-field
// layout and the skid-buffer state encoding.
package rv_imm_pkg;

   localparam logic [2:0] IMM_U   = 3'b000;
   localparam logic [2:0] IMM_J   = 3'b001;
   localparam logic [2:0] IMM_I   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_S   = 3'b100;
   localparam logic [2:0] IMM_SH  = 3'b101;
   localparam logic [2:0] IMM_Z   = 3'b110;
   localparam logic [2:0] IMM_RSV = 3'b111;

   localparam int SEL_UNSIGNED = 3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/immediate_select_pipe_if.sv
// Handshake bundle between decode (master) and the immediate pipe (slave).
interface immediate_select_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [31:0]      INSTRUCTION;
   logic [3:0]       SELECT;
   logic [TAG_W-1:0] IN_TAG;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [XLEN-1:0]  OUTPUT;
   logic [TAG_W-1:0] OUT_TAG;
   logic             ILLEGAL;

   modport master (
      output IN_VALID, INSTRUCTION, SELECT, IN_TAG, OUT_READY,
      input  IN_READY, OUT_VALID, OUTPUT, OUT_TAG, ILLEGAL
   );

   modport slave (
      input  IN_VALID, INSTRUCTION, SELECT, IN_TAG, OUT_READY,
      output IN_READY, OUT_VALID, OUTPUT, OUT_TAG, ILLEGAL
   );
endinterface

// File: rtl/immediate_select_pipe_extract.sv
// Combinational immediate extraction and extension to XLEN for every RV
// immediate format; reserved format yields zero and flags illegal.
module immediate_extract
   import rv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [3:0]      i_select,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   logic [31:0] w_imm32;
   logic        w_sext;
   logic        w_msb;
   logic        w_unused_opcode;

   assign w_unused_opcode = ^i_instr[6:0];
   assign w_sext          = ~i_select[SEL_UNSIGNED];
   assign w_msb           = i_instr[31] & w_sext;

   always_comb begin
      w_imm32   = '0;
      o_illegal = 1'b0;
      case (i_select[2:0])
         IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{w_msb}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
         IMM_I:   w_imm32 = {{20{w_msb}}, i_instr[31:20]};
         IMM_B:   w_imm32 = {{19{w_msb}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
         IMM_S:   w_imm32 = {{20{w_msb}}, i_instr[31:25], i_instr[11:7]};
         IMM_SH:  w_imm32 = (XLEN == 64) ? {26'b0, i_instr[25:20]}
                                         : {27'b0, i_instr[24:20]};
         IMM_Z:   w_imm32 = {27'b0, i_instr[19:15]};
         default: o_illegal = 1'b1;
      endcase
   end

   // Bit 31 of the 32-bit result is already the extension bit for every
   // signed format, and zero for shamt/zimm/reserved.
   if (XLEN == 64) begin : g_x64
      assign o_imm = {{32{w_imm32[31] & w_sext}}, w_imm32};
   end else begin : g_x32
      assign o_imm = w_imm32[XLEN-1:0];
   end

endmodule

// File: rtl/immediate_select_pipe.sv
// Registered immediate generator with valid/ready handshake and a two-entry
// skid buffer so decode back-pressure never loses an instruction.
module immediate_select_pipe
   import rv_imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    FLUSH,
   immediate_select_pipe_if.slave  bus
);
   // state    | meaning
   // ST_EMPTY | no entries held, OUT_VALID=0
   // ST_ONE   | MAIN holds the presented entry
   // ST_FULL  | MAIN presented, SKID holds the next entry, IN_READY=0

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immediate_select_pipe: XLEN must be 32 or 64");
   end

   pipe_state_t      r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [XLEN-1:0]  r_main_imm;
   logic [TAG_W-1:0] r_main_tag;
   logic             r_main_ill;
   logic [XLEN-1:0]  r_skid_imm;
   logic [TAG_W-1:0] r_skid_tag;
   logic             r_skid_ill;

   logic [XLEN-1:0]  w_ext_imm;
   logic             w_ext_ill;
   logic             w_in_fire;
   logic             w_out_fire;

   immediate_extract #(.XLEN(XLEN)) u_extract (
      .i_instr   (bus.INSTRUCTION),
      .i_select  (bus.SELECT),
      .o_imm     (w_ext_imm),
      .o_illegal (w_ext_ill)
   );

   assign w_in_fire  = bus.IN_VALID & r_in_ready;
   assign w_out_fire = r_out_valid & bus.OUT_READY;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_main_imm  <= '0;
         r_main_tag  <= '0;
         r_main_ill  <= 1'b0;
         r_skid_imm  <= '0;
         r_skid_tag  <= '0;
         r_skid_ill  <= 1'b0;
      end else if (FLUSH) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_imm  <= w_ext_imm;
                  r_main_tag  <= bus.IN_TAG;
                  r_main_ill  <= w_ext_ill;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               case ({w_in_fire, w_out_fire})
                  2'b10: begin
                     r_skid_imm <= w_ext_imm;
                     r_skid_tag <= bus.IN_TAG;
                     r_skid_ill <= w_ext_ill;
                     r_in_ready <= 1'b0;
                     r_state    <= ST_FULL;
                  end
                  2'b01: begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_EMPTY;
                  end
                  2'b11: begin
                     r_main_imm <= w_ext_imm;
                     r_main_tag <= bus.IN_TAG;
                     r_main_ill <= w_ext_ill;
                  end
                  default: ;
               endcase
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  r_main_imm <= r_skid_imm;
                  r_main_tag <= r_skid_tag;
                  r_main_ill <= r_skid_ill;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.IN_READY  = r_in_ready;
   assign bus.OUT_VALID = r_out_valid;
   assign bus.OUTPUT    = r_main_imm;
   assign bus.OUT_TAG   = r_main_tag;
   assign bus.ILLEGAL   = r_main_ill;

endmodule

// File: tb/tb_immediate_select_pipe.sv
// Directed and random checks of immediate_select_pipe at XLEN=32 and XLEN=64
// driven side by side with identical stimulus.
module tb_immediate_select_pipe;

   logic CLK = 1'b0;
   logic RESETN;
   logic FLUSH;

   immediate_select_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
   immediate_select_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

   immediate_select_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
      .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .bus(b32));
   immediate_select_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
      .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .bus(b64));

   always #5 CLK = ~CLK;

   int n_asserts = 0;
   int n_fail    = 0;

   // hand-computed vectors: instruction, select, expected XLEN=32, expected XLEN=64
   logic [31:0] v_ins [14] = '{32'hFFF00093, 32'hFFF00093, 32'hFE000EE3, 32'h123450B7,
                               32'h800000B7, 32'h4070D093, 32'h4070D093, 32'hFE112E23,
                               32'h0080006F, 32'h7C0FD073, 32'h03F0D093, 32'hFE000EE3,
                               32'hFFDFF06F, 32'h800000B7};
   logic [3:0]  v_sel [14] = '{4'b0010, 4'b1010, 4'b0011, 4'b0000, 4'b0000, 4'b0101, 4'b0111,
                               4'b0100, 4'b0001, 4'b0110, 4'b0101, 4'b1011, 4'b0001, 4'b1000};
   logic [63:0] v_e32 [14] = '{64'hFFFFFFFF, 64'h00000FFF, 64'hFFFFFFFC, 64'h12345000,
                               64'h80000000, 64'h7, 64'h0, 64'hFFFFFFFC, 64'h8, 64'h1F,
                               64'h1F, 64'h1FFC, 64'hFFFFFFFC, 64'h80000000};
   logic [63:0] v_e64 [14] = '{64'hFFFFFFFFFFFFFFFF, 64'h0FFF, 64'hFFFFFFFFFFFFFFFC,
                               64'h12345000, 64'hFFFFFFFF80000000, 64'h7, 64'h0,
                               64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h1F, 64'h3F, 64'h1FFC,
                               64'hFFFFFFFFFFFFFFFC, 64'h0000000080000000};

   typedef struct {
      logic [63:0] e32;
      logic [63:0] e64;
      logic [7:0]  tag;
      logic        ill;
   } ent_t;

   ent_t        q[$];
   ent_t        ent;
   logic        s_v;
   logic        s_r;
   logic [31:0] s_ins;
   logic [3:0]  s_sel;
   logic [7:0]  s_tag;
   logic        pend;
   logic        in_f;
   logic        out_f;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] sel,
                        input logic [7:0] tag);
      b32.IN_VALID = v; b32.INSTRUCTION = ins; b32.SELECT = sel; b32.IN_TAG = tag;
      b64.IN_VALID = v; b64.INSTRUCTION = ins; b64.SELECT = sel; b64.IN_TAG = tag;
   endtask

   task automatic ready(input logic r);
      b32.OUT_READY = r;
      b64.OUT_READY = r;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic ov, input logic ir,
                          input logic [63:0] e32, input logic [63:0] e64,
                          input logic [7:0] et, input logic eill);
      chk({tag, "/ov32"}, {63'b0, b32.OUT_VALID}, {63'b0, ov});
      chk({tag, "/ov64"}, {63'b0, b64.OUT_VALID}, {63'b0, ov});
      chk({tag, "/ir32"}, {63'b0, b32.IN_READY}, {63'b0, ir});
      chk({tag, "/ir64"}, {63'b0, b64.IN_READY}, {63'b0, ir});
      if (ov) begin
         chk({tag, "/imm32"}, {32'b0, b32.OUTPUT}, e32);
         chk({tag, "/imm64"}, b64.OUTPUT, e64);
         chk({tag, "/tag32"}, {56'b0, b32.OUT_TAG}, {56'b0, et});
         chk({tag, "/tag64"}, {56'b0, b64.OUT_TAG}, {56'b0, et});
         chk({tag, "/ill32"}, {63'b0, b32.ILLEGAL}, {63'b0, eill});
         chk({tag, "/ill64"}, {63'b0, b64.ILLEGAL}, {63'b0, eill});
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/imm32"}, {32'b0, b32.OUTPUT}, 64'h0);
      chk({tag, "/imm64"}, b64.OUTPUT, 64'h0);
      chk({tag, "/tag"}, {48'b0, b32.OUT_TAG, b64.OUT_TAG}, 64'h0);
      chk({tag, "/ill"}, {62'b0, b32.ILLEGAL, b64.ILLEGAL}, 64'h0);
   endtask

   // left-justify the raw field, then shift it back down arithmetically or logically
   function automatic logic [63:0] ext(input logic [63:0] left, input int w, input logic s);
      logic signed [63:0] t;
      t = left;
      if (s) t = t >>> (64 - w);
      else   t = t >> (64 - w);
      return t;
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [3:0] sel,
                                           input int xlen);
      logic [63:0] v;
      logic        s;
      s = ~sel[3];
      case (sel[2:0])
         3'd0:    v = ext({ins[31:12], 12'h0, 32'h0}, 32, s);
         3'd1:    v = ext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'h0}, 21, s);
         3'd2:    v = ext({ins[31:20], 52'h0}, 12, s);
         3'd3:    v = ext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'h0}, 13, s);
         3'd4:    v = ext({ins[31:25], ins[11:7], 52'h0}, 12, s);
         3'd5:    v = (xlen == 64) ? {58'h0, ins[25:20]} : {59'h0, ins[24:20]};
         3'd6:    v = {59'h0, ins[19:15]};
         default: v = 64'h0;
      endcase
      if (xlen == 32) v[63:32] = 32'h0;
      return v;
   endfunction

   initial begin
      RESETN = 1'b0;
      FLUSH  = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 8'h0);
      ready(1'b1);
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
      chk_zero("reset");
      RESETN = 1'b1;
      tick();

      // back-to-back stream of every format, one result per cycle
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, v_ins[i], v_sel[i], 8'(8'h10 + i));
         if (i == 0) begin
            #1;
            chk_out("latency", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
         end
         tick();
         chk_out($sformatf("vec%0d", i), 1'b1, 1'b1, v_e32[i], v_e64[i], 8'(8'h10 + i),
                 v_sel[i][2:0] == 3'b111);
      end
      drive(1'b0, 32'h0, 4'h0, 8'h0);
      tick();
      chk_out("drain", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);

      // four-cycle consumer stall with tags 1,2,3 offered
      ready(1'b0);
      drive(1'b1, 32'hFFF00093, 4'b0010, 8'd1);
      tick();
      chk_out("stall_a", 1'b1, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'd1, 1'b0);
      drive(1'b1, 32'h123450B7, 4'b0000, 8'd2);
      tick();
      chk_out("stall_b", 1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'd1, 1'b0);
      drive(1'b1, 32'h7C0FD073, 4'b0110, 8'd3);
      tick();
      chk_out("stall_c", 1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'd1, 1'b0);
      tick();
      chk_out("stall_d", 1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'd1, 1'b0);
      ready(1'b1);
      tick();
      chk_out("release_a", 1'b1, 1'b1, 64'h12345000, 64'h12345000, 8'd2, 1'b0);
      tick();
      chk_out("release_b", 1'b1, 1'b1, 64'h1F, 64'h1F, 8'd3, 1'b0);
      drive(1'b0, 32'h0, 4'h0, 8'h0);
      tick();
      chk_out("release_c", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);

      // flush from FULL with a simultaneous input
      ready(1'b0);
      drive(1'b1, 32'hFFF00093, 4'b1010, 8'd4);
      tick();
      drive(1'b1, 32'hFE000EE3, 4'b0011, 8'd5);
      tick();
      chk_out("pre_flush", 1'b1, 1'b0, 64'hFFF, 64'hFFF, 8'd4, 1'b0);
      FLUSH = 1'b1;
      drive(1'b1, 32'h800000B7, 4'b0000, 8'd6);
      tick();
      chk_out("flush", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
      FLUSH = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 8'h0);
      ready(1'b1);
      tick();
      chk_out("post_flush_a", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
      tick();
      chk_out("post_flush_b", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);

      // asynchronous reset while FULL and stalled
      ready(1'b0);
      drive(1'b1, 32'hFE112E23, 4'b0100, 8'd7);
      tick();
      drive(1'b1, 32'h0080006F, 4'b0001, 8'd8);
      tick();
      chk_out("pre_reset", 1'b1, 1'b0, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 8'd7, 1'b0);
      #2;
      RESETN = 1'b0;
      #1;
      chk_out("async_reset", 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
      chk_zero("async_reset");
      drive(1'b0, 32'h0, 4'h0, 8'h0);
      tick();
      RESETN = 1'b1;
      tick();

      // random valid/ready soak against a queue model
      pend  = 1'b0;
      s_v   = 1'b0;
      s_ins = 32'h0;
      s_sel = 4'h0;
      s_tag = 8'h80;
      for (int c = 0; c < 400; c++) begin
         if (!pend) begin
            s_v   = ($urandom_range(0, 2) != 0);
            s_ins = $urandom;
            s_sel = 4'($urandom_range(0, 15));
            s_tag = s_tag + 8'd1;
         end
         s_r = ($urandom_range(0, 2) != 0);
         drive(s_v, s_ins, s_sel, s_tag);
         ready(s_r);
         #1;
         if (q.size() > 0)
            chk_out($sformatf("soak%0d", c), 1'b1, q.size() < 2, q[0].e32, q[0].e64,
                    q[0].tag, q[0].ill);
         else
            chk_out($sformatf("soak%0d", c), 1'b0, 1'b1, 64'h0, 64'h0, 8'h0, 1'b0);
         in_f  = s_v && (q.size() < 2);
         out_f = (q.size() > 0) && s_r;
         if (out_f) void'(q.pop_front());
         if (in_f) begin
            ent.e32 = ref_imm(s_ins, s_sel, 32);
            ent.e64 = ref_imm(s_ins, s_sel, 64);
            ent.tag = s_tag;
            ent.ill = (s_sel[2:0] == 3'b111);
            q.push_back(ent);
         end
         pend = s_v && !in_f;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
